cpu_bus_wb: RTL and testbench
=============================

CPU_BUS_WB -- requirements
Module: cpu_bus_wb

Interface
REQ-001 Parameter WB_DEPTH, default 4, number of posted-write entries; power of two, >= 2.
REQ-002 Parameter IRQ_WIDTH, default 16, width of the interrupt request vector.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 bus_stb  out  1  bus cycle request; held until bus_ack.
REQ-006 bus_we  out  1  1 = bus write, 0 = bus read.
REQ-007 bus_addr  out  30  word address [31:2].
REQ-008 bus_din  in  32  bus read data; big-endian byte order, byte 0 = [31:24].
REQ-009 bus_dout  out  32  bus write data.
REQ-010 bus_ack  in  1  bus cycle complete.
REQ-011 bus_irq  in  IRQ_WIDTH  interrupt requests from devices.
REQ-012 cpu_stb, cpu_we  in  1 each  CPU request and direction.
REQ-013 cpu_size  in  2  00 byte, 01 halfword, 1x word.
REQ-014 cpu_addr  in  32  byte address; sub-word bits beyond the access size are ignored.
REQ-015 cpu_dout  in  32  CPU write data, right-aligned.
REQ-016 cpu_din  out  32  CPU read data, zero-extended, right-aligned.
REQ-017 cpu_ack  out  1  CPU request complete.
REQ-018 cpu_irq  out  IRQ_WIDTH  equals bus_irq, combinational.
REQ-019 wb_empty  out  1  1 when the write buffer holds no entries.

Function
REQ-020 CPU writes of any size are posted into a FIFO entry {word address, 32-bit lane-aligned data, 4-bit byte mask}; cpu_ack = 1 in the same cycle when the FIFO is not full, otherwise 0 until a slot frees.
REQ-021 Byte mask: byte lane addr[1:0]; halfword lanes addr[1]*2 and addr[1]*2+1; word 1111; data is replicated onto the selected lanes.
REQ-022 Push and pop in the same cycle are both honoured when the FIFO is full; the count is unchanged and the accepting cpu_ack is asserted.
REQ-023 Bus FSM states: IDLE, CPU_RD, DR_RD, DR_WR.
REQ-024 IDLE, FIFO non-empty: go to DR_WR if the head mask is 1111, else DR_RD; draining has priority over CPU reads.
REQ-025 IDLE, FIFO empty with cpu_stb=1 and cpu_we=0: go to CPU_RD; a CPU read never bypasses posted writes.
REQ-026 CPU_RD: bus_stb=1, bus_we=0, bus_addr=cpu_addr[31:2]; cpu_din is the selected lane zero-extended; cpu_ack=bus_ack; return to IDLE on ack.
REQ-027 DR_RD: bus read of the head address; on ack, register the head data merged into bus_din under the mask; go to DR_WR.
REQ-028 DR_WR: bus_stb=1, bus_we=1; bus_dout is the head data when the mask is 1111, else the merge register; on ack pop the head and return to IDLE.
REQ-029 bus_stb, bus_we, bus_addr and bus_dout remain stable from assertion until the cycle of bus_ack.
REQ-030 In IDLE bus_stb = 0; in every state other than CPU_RD, cpu_ack is driven only by REQ-020.
REQ-031 FIFO pointers are log2(WB_DEPTH) bits and wrap modulo WB_DEPTH; the count is log2(WB_DEPTH)+1 bits.

Reset
REQ-032 While rst = 0: FSM in IDLE, FIFO pointers and count at 0, merge register at 0.
REQ-033 While rst = 0: bus_stb, bus_we, cpu_ack at 0; bus_addr, bus_dout, cpu_din at 0; wb_empty at 1.
REQ-034 Reset asserted mid-transaction abandons it, discards all posted writes, and drops bus_stb asynchronously.

Structure
REQ-035 Size encodings, FSM state encodings and the lane-mask function belong in a shared cpu_bus_pkg.
REQ-036 The FIFO is a sub-module, wbuf_fifo (parametrised by depth and entry width), with push, pop, full, empty and head outputs.

Verification
REQ-037 Word write 0x12345678 to 0x100, bus_ack after 2 cycles -> cpu_ack in the request cycle; bus write 0x12345678 to word 0x40; wb_empty returns to 1.
REQ-038 Byte write 0xAB to 0x101, memory word 0x11223344 -> bus read of word 0x40, then bus write 0x11AB3344.
REQ-039 WB_DEPTH writes with bus_ack held low, then one more write -> the extra cpu_ack stays 0 until the first drain ack, then asserts in that cycle.
REQ-040 Halfword write 0xBEEF to 0x202 followed by a halfword read of 0x202 -> the read bus cycle starts only after the write's bus_ack; cpu_din = 0x0000BEEF.
REQ-041 rst pulsed low during DR_RD with 3 entries posted -> bus_stb = 0 immediately, wb_empty = 1, and no bus write is issued after release.
REQ-042 bus_irq = 0x8001 -> cpu_irq = 0x8001 in the same cycle, in every FSM state.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared encodings and byte-lane helpers for the CPU-to-bus bridge.
// Byte lane i of a bus word is bits [31-8*i -: 8] (big-endian, lane 0 = [31:24]).
package cpu_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_DR_RD  = 2'd2,
    ST_DR_WR  = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Mask bit i enables byte lane i; sub-word address bits beyond the size are ignored.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {4{data[7:0]}};
      SIZE_HALF: r = {2{data[15:0]}};
      default:   r = data;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_read(input logic [1:0] size, input logic [1:0] lo,
                                            input logic [31:0] word);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: begin
        case (lo)
          2'd0:    r = {24'd0, word[31:24]};
          2'd1:    r = {24'd0, word[23:16]};
          2'd2:    r = {24'd0, word[15:8]};
          default: r = {24'd0, word[7:0]};
        endcase
      end
      SIZE_HALF: r = lo[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
      default:   r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] new_data, input logic [31:0] old_data,
                                             input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = mask[i] ? new_data[31-8*i -: 8] : old_data[31-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO: power-of-two depth, wrapping pointers, count one bit wider.
// A push while full is legal only together with a pop; the caller enforces that.
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_bus_wb.sv
// CPU-to-bus bridge: posts CPU writes into a FIFO and drains them (read-modify-write
// for partial words) ahead of any CPU read, so reads never bypass posted writes.
module cpu_bus_wb
  import cpu_bus_pkg::*;
#(
  parameter int WB_DEPTH  = 4,
  parameter int IRQ_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 bus_stb,
  output logic                 bus_we,
  output logic [29:0]          bus_addr,
  input  logic [31:0]          bus_din,
  output logic [31:0]          bus_dout,
  input  logic                 bus_ack,
  input  logic [IRQ_WIDTH-1:0] bus_irq,
  input  logic                 cpu_stb,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_size,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_dout,
  output logic [31:0]          cpu_din,
  output logic                 cpu_ack,
  output logic [IRQ_WIDTH-1:0] cpu_irq,
  output logic                 wb_empty
);

  bus_state_e         state_q, state_d;
  logic [31:0]        merge_q, merge_d;
  wb_entry_t          push_entry_s, head_s;
  logic [ENTRY_W-1:0] head_bits_s;
  logic               push_s, pop_s, rd_ack_s;
  logic               fifo_full_s, fifo_empty_s;

  wbuf_fifo #(
    .DEPTH(WB_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_wbuf (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .din_i  (push_entry_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .head_o (head_bits_s)
  );

  assign head_s   = head_bits_s;
  assign wb_empty = fifo_empty_s;
  assign cpu_irq  = bus_irq;

  // Lane-aligned entry built from the current CPU write request.
  always_comb begin
    push_entry_s.addr = cpu_addr[31:2];
    push_entry_s.data = lane_data(cpu_size, cpu_dout);
    push_entry_s.mask = lane_mask(cpu_size, cpu_addr[1:0]);
  end

  // A full FIFO still accepts when the head pops in the same cycle.
  assign push_s  = rst & cpu_stb & cpu_we & (state_q != ST_CPU_RD) & (~fifo_full_s | pop_s);
  assign cpu_ack = push_s | rd_ack_s;

  // FSM state and read-modify-write merge register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      merge_q <= 32'd0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

  // Next-state and bus/CPU outputs decoded from the current state.
  always_comb begin
    state_d  = state_q;
    merge_d  = merge_q;
    pop_s    = 1'b0;
    rd_ack_s = 1'b0;
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = 30'd0;
    bus_dout = 32'd0;
    cpu_din  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = (head_s.mask == 4'b1111) ? ST_DR_WR : ST_DR_RD;
        end else if (cpu_stb && !cpu_we) begin
          state_d = ST_CPU_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CPU_RD: begin
        bus_stb  = 1'b1;
        bus_addr = cpu_addr[31:2];
        cpu_din  = lane_read(cpu_size, cpu_addr[1:0], bus_din);
        rd_ack_s = bus_ack;
        state_d  = bus_ack ? ST_IDLE : ST_CPU_RD;
      end
      ST_DR_RD: begin
        bus_stb  = 1'b1;
        bus_addr = head_s.addr;
        if (bus_ack) begin
          merge_d = lane_merge(head_s.data, bus_din, head_s.mask);
          state_d = ST_DR_WR;
        end else begin
          state_d = ST_DR_RD;
        end
      end
      ST_DR_WR: begin
        bus_stb  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = head_s.addr;
        bus_dout = (head_s.mask == 4'b1111) ? head_s.data : merge_q;
        pop_s    = bus_ack;
        state_d  = bus_ack ? ST_IDLE : ST_DR_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_wb.sv
// Self-checking bench for cpu_bus_wb: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-addressed memory model.
module tb_cpu_bus_wb;

  localparam int DEPTH = 4;
  localparam int IRQW  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            bus_stb, bus_we, bus_ack, cpu_stb, cpu_we, cpu_ack, wb_empty;
  logic [29:0]     bus_addr;
  logic [31:0]     bus_din, bus_dout, cpu_addr, cpu_dout, cpu_din;
  logic [1:0]      cpu_size;
  logic [IRQW-1:0] bus_irq, cpu_irq;

  always #5 clk = ~clk;

  cpu_bus_wb #(.WB_DEPTH(DEPTH), .IRQ_WIDTH(IRQW)) dut (
    .clk(clk), .rst(rst),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_ack(bus_ack), .bus_irq(bus_irq),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_irq(cpu_irq),
    .wb_empty(wb_empty)
  );

  typedef struct { logic we; logic [29:0] addr; logic [31:0] data; } txn_t;
  typedef struct {
    logic [1:0] sz; logic [31:0] addr; logic [31:0] wdata; logic [31:0] init;
    bit rd; logic [31:0] word; logic [31:0] rdata;
  } vec_t;

  txn_t act_q[$];
  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  bit   ack_en = 1'b1;
  logic [31:0] bus_mem [logic [29:0]];
  logic [7:0]  ref_b   [logic [31:0]];
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : 32'd0;
  endfunction

  // Reference model: memory as individual bytes, big-endian words.
  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'd0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < 4; k++) r = (r << 8) | 32'(ref_byte({wa, 2'b00} + 32'(k)));
    return r;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic ref_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = nbytes(sz);
    logic [31:0] base = a & ~32'(n - 1);
    if (n < 4) exp_q.push_back('{1'b0, a[31:2], ref_word(a[31:2])});
    for (int k = 0; k < n; k++) ref_b[base + 32'(k)] = 8'(d >> (8 * (n - 1 - k)));
    exp_q.push_back('{1'b1, a[31:2], ref_word(a[31:2])});
  endtask

  task automatic ref_read(input logic [1:0] sz, input logic [31:0] a, output logic [31:0] v);
    int n = nbytes(sz);
    logic [31:0] base = a & ~32'(n - 1);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_byte(base + 32'(k)));
    exp_q.push_back('{1'b0, a[31:2], ref_word(a[31:2])});
  endtask

  // CPU-side drivers: called and returning at posedge+1.
  task automatic cpu_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           output int waited);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_size = sz; cpu_addr = a; cpu_dout = d; waited = 0;
    @(negedge clk);
    while (!cpu_ack && waited < 200) begin waited++; @(negedge clk); end
    if (!cpu_ack) begin checks++; errors++; $display("FAIL cpu_write_timeout: no cpu_ack for addr %h", a); end
    @(posedge clk); #1;
    cpu_stb = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] sz, input logic [31:0] a, output logic [31:0] d);
    int waited = 0;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_size = sz; cpu_addr = a;
    @(negedge clk);
    while (!cpu_ack && waited < 200) begin waited++; @(negedge clk); end
    if (!cpu_ack) begin checks++; errors++; $display("FAIL cpu_read_timeout: no cpu_ack for addr %h", a); end
    d = cpu_din;
    @(posedge clk); #1;
    cpu_stb = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (!(wb_empty && !bus_stb) && n < 500) begin n++; @(negedge clk); end
    if (!(wb_empty && !bus_stb)) begin checks++; errors++; $display("FAIL drain_timeout: buffer never drained"); end
    @(posedge clk); #1;
  endtask

  // Bus device: acks after lat cycles, logs transactions, checks request stability.
  initial begin : responder
    int wait_cnt = 0;
    logic pv = 1'b0;
    logic pwe;
    logic [29:0] pa;
    logic [31:0] pd;
    forever begin
      @(posedge clk); #1;
      if (!rst || bus_ack) begin
        bus_ack = 1'b0; wait_cnt = 0; pv = 1'b0;
      end else if (bus_stb) begin
        if (pv) begin
          chk("bus_hold_we", 32'(bus_we), 32'(pwe));
          chk("bus_hold_addr", 32'(bus_addr), 32'(pa));
          chk("bus_hold_dout", bus_dout, pd);
        end
        pv = 1'b1; pwe = bus_we; pa = bus_addr; pd = bus_dout;
        if (ack_en) begin
          if (wait_cnt >= lat) begin
            bus_ack = 1'b1;
            if (bus_we) begin
              bus_mem[bus_addr] = bus_dout;
              act_q.push_back('{1'b1, bus_addr, bus_dout});
            end else begin
              bus_din = mem_rd(bus_addr);
              act_q.push_back('{1'b0, bus_addr, bus_din});
            end
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        pv = 1'b0;
      end
    end
  end

  // Interrupt pass-through, varied every cycle across all FSM states.
  initial begin : irq_mon
    forever begin
      @(posedge clk); #2;
      bus_irq = ($urandom_range(0, 3) == 0) ? 16'h8001 : 16'($urandom);
      @(negedge clk);
      chk("cpu_irq", 32'(cpu_irq), 32'(bus_irq));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int w, n;
    logic [31:0] rd, ev;
    logic [1:0]  sz;
    logic [31:0] a, d;

    vecs[0] = '{2'b10, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{2'b00, 32'h0000_0101, 32'h0000_00AB, 32'h1122_3344, 1'b1, 32'h11AB_3344, 32'h0000_00AB};
    vecs[2] = '{2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'hCAFE_0000, 1'b1, 32'hCAFE_BEEF, 32'h0000_BEEF};
    vecs[3] = '{2'b01, 32'h0000_0301, 32'h0000_1234, 32'hAABB_CCDD, 1'b1, 32'h1234_CCDD, 32'h0000_1234};
    vecs[4] = '{2'b00, 32'h0000_0403, 32'h0000_005A, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FF5A, 32'h0000_005A};
    vecs[5] = '{2'b00, 32'h0000_0500, 32'hFFFF_FFC3, 32'h0000_0000, 1'b1, 32'hC300_0000, 32'h0000_00C3};
    vecs[6] = '{2'b11, 32'h0000_0603, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7] = '{2'b01, 32'h0000_0706, 32'hFFFF_AA55, 32'h1122_3344, 1'b1, 32'h1122_AA55, 32'h0000_AA55};

    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'd0; cpu_dout = 32'd0;
    bus_ack = 1'b0; bus_din = 32'd0; bus_irq = 16'd0;

    // Reset state, with a CPU write request pending.
    repeat (2) @(negedge clk);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'hFFFF_FFFF; cpu_dout = 32'hFFFF_FFFF;
    #1;
    chk("rst_bus_stb", 32'(bus_stb), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_dout", bus_dout, 32'd0);
    chk("rst_cpu_din", cpu_din, 32'd0);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    cpu_stb = 1'b0; cpu_we = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Vector table: write, drain, read back; bus acks two cycles after request.
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      bus_mem[vecs[i].addr[31:2]] = vecs[i].init;
      act_q.delete();
      cpu_write(vecs[i].sz, vecs[i].addr, vecs[i].wdata, w);
      chk("tbl_ack_cycle", 32'(w), 32'd0);
      wait_drain();
      chk("tbl_wb_empty", 32'(wb_empty), 32'd1);
      cpu_read(vecs[i].sz, vecs[i].addr, rd);
      chk("tbl_rdata", rd, vecs[i].rdata);
      chk("tbl_txn_count", 32'(act_q.size()), vecs[i].rd ? 32'd3 : 32'd2);
      if (act_q.size() == (vecs[i].rd ? 3 : 2)) begin
        n = 0;
        if (vecs[i].rd) begin
          chk("tbl_rmw_rd_we", 32'(act_q[0].we), 32'd0);
          chk("tbl_rmw_rd_addr", 32'(act_q[0].addr), 32'(vecs[i].addr[31:2]));
          n = 1;
        end
        chk("tbl_wr_we", 32'(act_q[n].we), 32'd1);
        chk("tbl_wr_addr", 32'(act_q[n].addr), 32'(vecs[i].addr[31:2]));
        chk("tbl_wr_data", act_q[n].data, vecs[i].word);
        chk("tbl_rd_after_wr_we", 32'(act_q[n+1].we), 32'd0);
        chk("tbl_rd_after_wr_addr", 32'(act_q[n+1].addr), 32'(vecs[i].addr[31:2]));
      end
    end

    // Fill the buffer with the bus stalled; the extra write waits for the first drain ack.
    ack_en = 1'b0; lat = 0;
    act_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write(2'b10, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), w);
      chk("full_fill_ack", 32'(w), 32'd0);
    end
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h1000 + 32'(4 * DEPTH);
    cpu_dout = 32'hA000_0000 + 32'(DEPTH);
    repeat (5) begin @(negedge clk); chk("full_hold_ack", 32'(cpu_ack), 32'd0); end
    @(posedge clk); #1;
    ack_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_ack && n < 50) begin chk("full_hold_ack", 32'(cpu_ack), 32'd0); n++; @(negedge clk); end
    chk("full_drain_ack", 32'(bus_ack), 32'd1);
    chk("full_ack_on_drain", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1;
    cpu_stb = 1'b0; cpu_we = 1'b0;
    wait_drain();
    chk("full_txn_count", 32'(act_q.size()), 32'(DEPTH + 1));
    for (int i = 0; i <= DEPTH && i < act_q.size(); i++) begin
      chk("full_txn_addr", 32'(act_q[i].addr), (32'h1000 + 32'(4 * i)) >> 2);
      chk("full_txn_data", act_q[i].data, 32'hA000_0000 + 32'(i));
    end

    // Randomized traffic against the byte-level reference model.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      bus_mem[30'((32'h8000 >> 2) + i)] = d;
      for (int k = 0; k < 4; k++) ref_b[32'h8000 + 32'(4 * i + k)] = 8'(d >> (24 - 8 * k));
    end
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 150; i++) begin
      lat = $urandom_range(0, 3);
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h8000 + 32'($urandom_range(0, 31));
      d   = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        ref_write(sz, a, d);
        cpu_write(sz, a, d, w);
      end else begin
        ref_read(sz, a, ev);
        cpu_read(sz, a, rd);
        chk("rnd_rdata", rd, ev);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    wait_drain();
    chk("rnd_txn_count", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk("rnd_txn_we", 32'(act_q[i].we), 32'(exp_q[i].we));
      chk("rnd_txn_addr", 32'(act_q[i].addr), 32'(exp_q[i].addr));
      chk("rnd_txn_data", act_q[i].data, exp_q[i].data);
    end

    // Reset during a drain read with three posted byte writes.
    ack_en = 1'b0; lat = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_write(2'b00, 32'h1101 + 32'(4 * i), 32'h0000_0077, w);
      chk("rst_post_ack", 32'(w), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("drrd_bus_stb", 32'(bus_stb), 32'd1);
    chk("drrd_bus_we", 32'(bus_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_bus_stb", 32'(bus_stb), 32'd0);
    chk("midrst_wb_empty", 32'(wb_empty), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ack_en = 1'b1;
    act_q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("postrst_no_bus_txn", 32'(act_q.size()), 32'd0);
    chk("postrst_wb_empty", 32'(wb_empty), 32'd1);
    chk("postrst_bus_stb", 32'(bus_stb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
